// File: rtl/vga_vram_arbiter.sv
// Shares one single-port synchronous VRAM between the display prefetch stream and a host port.
// The display has priority. A starvation guard forces a host slot after MAXBURST display grants.
module vga_vram_arbiter #(
    parameter int PWIDTH   = 8,
    parameter int AWIDTH   = 20,
    parameter int LATENCY  = 2,
    parameter int MAXBURST = 8
) (
    input  logic              clk_core,
    input  logic              rst_core,
    input  logic              disp_rd,
    input  logic [AWIDTH-1:0] disp_addr,
    output logic              disp_busy,
    output logic [PWIDTH-1:0] disp_data,
    output logic              disp_vld,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [AWIDTH-1:0] host_addr,
    input  logic [PWIDTH-1:0] host_wdata,
    output logic              host_ack,
    output logic [PWIDTH-1:0] host_rdata,
    output logic              host_rvld,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [PWIDTH-1:0] mem_wdata,
    input  logic [PWIDTH-1:0] mem_rdata,
    output logic              arb_err
);

    localparam int CW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAXBURST - 1);

    logic               host_slot;
    logic [CW-1:0]      starve_cnt;
    logic [LATENCY-1:0] pipe_vld;
    logic [LATENCY-1:0] pipe_own;
    logic               disp_grant;
    logic               issue_rd;
    logic               host_slot_next;

    // A registered host slot overrides the display, which keeps disp_busy free of combinational paths.
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = disp_addr;
        host_ack = 1'b0;
        if (host_slot) begin
            mem_en   = 1'b1;
            mem_we   = host_we;
            mem_addr = host_addr;
            host_ack = 1'b1;
        end else if (disp_rd) begin
            mem_en   = 1'b1;
        end
    end

    assign mem_wdata      = host_wdata;
    assign disp_grant     = disp_rd & ~host_slot;
    assign issue_rd       = mem_en & ~mem_we;
    assign host_slot_next = host_req & ~host_slot & (~disp_rd | (starve_cnt == CNT_MAX));

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            host_slot  <= 1'b0;
            starve_cnt <= '0;
            pipe_vld   <= '0;
            pipe_own   <= '0;
            arb_err    <= 1'b0;
        end else begin
            host_slot <= host_slot_next;

            if (!host_req || host_slot) begin
                starve_cnt <= '0;
            end else if (disp_grant && (starve_cnt != CNT_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            // Owner pipeline tracks which requester each in-flight read belongs to.
            pipe_vld[0] <= issue_rd;
            pipe_own[0] <= ~host_slot;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_own[i] <= pipe_own[i-1];
            end

            if (disp_rd && host_slot) begin
                arb_err <= 1'b1;
            end
        end
    end

    assign disp_busy  = host_slot;
    assign disp_data  = mem_rdata;
    assign host_rdata = mem_rdata;
    assign disp_vld   = pipe_vld[LATENCY-1] & pipe_own[LATENCY-1];
    assign host_rvld  = pipe_vld[LATENCY-1] & ~pipe_own[LATENCY-1];

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Bench for vga_vram_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// The bench includes a behavioural VRAM with LATENCY-cycle reads.
module tb_vga_vram_arbiter;

    localparam int PWIDTH   = 8;
    localparam int AWIDTH   = 20;
    localparam int LATENCY  = 2;
    localparam int MAXBURST = 8;

    logic              clk_core = 1'b0;
    logic              rst_core;
    logic              disp_rd;
    logic [AWIDTH-1:0] disp_addr;
    logic              disp_busy;
    logic [PWIDTH-1:0] disp_data;
    logic              disp_vld;
    logic              host_req;
    logic              host_we;
    logic [AWIDTH-1:0] host_addr;
    logic [PWIDTH-1:0] host_wdata;
    logic              host_ack;
    logic [PWIDTH-1:0] host_rdata;
    logic              host_rvld;
    logic              mem_en;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [PWIDTH-1:0] mem_wdata;
    logic [PWIDTH-1:0] mem_rdata;
    logic              arb_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int                due;
        bit                owner;
        logic [PWIDTH-1:0] data;
    } ret_t;

    logic [PWIDTH-1:0] ref_mem [0:4095];

    vga_vram_arbiter #(
        .PWIDTH(PWIDTH), .AWIDTH(AWIDTH), .LATENCY(LATENCY), .MAXBURST(MAXBURST)
    ) dut (
        .clk_core(clk_core), .rst_core(rst_core),
        .disp_rd(disp_rd), .disp_addr(disp_addr), .disp_busy(disp_busy),
        .disp_data(disp_data), .disp_vld(disp_vld),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .host_rvld(host_rvld),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .arb_err(arb_err)
    );

    always #5 clk_core = ~clk_core;

    function automatic logic [PWIDTH-1:0] seed_data(input int a);
        return PWIDTH'(a) ^ 8'h5A;
    endfunction

    // Behavioural VRAM: seeded on the first edge, reads appear LATENCY cycles after issue.
    logic [PWIDTH-1:0] vram [0:4095];
    logic [PWIDTH-1:0] rd_pipe [0:LATENCY-1];
    bit                vram_init = 1'b0;

    always @(posedge clk_core) begin
        if (!vram_init) begin
            for (int i = 0; i < 4096; i++) vram[i] <= seed_data(i);
            vram_init <= 1'b1;
        end else begin
            if (mem_en && mem_we) vram[mem_addr[11:0]] <= mem_wdata;
            if (mem_en && !mem_we) rd_pipe[0] <= vram[mem_addr[11:0]];
            for (int i = 1; i < LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    assign mem_rdata = rd_pipe[LATENCY-1];

    task automatic next_cycle();
        @(posedge clk_core);
        #1;
    endtask

    task automatic mid_cycle();
        @(negedge clk_core);
    endtask

    task automatic idle_inputs();
        disp_rd    = 1'b0;
        disp_addr  = '0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
    endtask

    task automatic test_reset();
        rst_core = 1'b1;
        next_cycle();
        next_cycle();
        mid_cycle();
        checks++;
        if ({disp_busy, disp_vld, host_ack, host_rvld, mem_en, mem_we, arb_err} !== 7'b0)
            $display("[TB] FAIL reset_outputs: got %b expected 0000000",
                     {disp_busy, disp_vld, host_ack, host_rvld, mem_en, mem_we, arb_err});
        next_cycle();
        rst_core = 1'b0;
        next_cycle();
        mid_cycle();
        checks++;
        if ({disp_busy, disp_vld, host_rvld, arb_err} !== 4'b0)
            $display("[TB] FAIL post_reset_idle: got %b expected 0000",
                     {disp_busy, disp_vld, host_rvld, arb_err});
        next_cycle();
    endtask

    task automatic test_display_only();
        int n;
        n = 12;
        for (int k = 0; k < n + LATENCY; k++) begin
            disp_rd   = (k < n);
            disp_addr = AWIDTH'(k);
            mid_cycle();
            checks++;
            if (disp_busy !== 1'b0 || mem_en !== (k < n) || host_rvld !== 1'b0) begin
                errors++;
                $display("[TB] FAIL disp_only_issue k=%0d: busy=%b en=%b rvld=%b expected busy=0 en=%b rvld=0",
                         k, disp_busy, mem_en, host_rvld, (k < n));
            end
            checks++;
            if (disp_vld !== (k >= LATENCY)) begin
                errors++;
                $display("[TB] FAIL disp_only_vld k=%0d: got %b expected %b", k, disp_vld, (k >= LATENCY));
            end
            if (k >= LATENCY) begin
                checks++;
                if (disp_data !== ref_mem[12'(k - LATENCY)]) begin
                    errors++;
                    $display("[TB] FAIL disp_only_data k=%0d: got %h expected %h",
                             k, disp_data, ref_mem[12'(k - LATENCY)]);
                end
            end
            next_cycle();
        end
        idle_inputs();
        mid_cycle();
        checks++;
        if (arb_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL disp_only_err: got %b expected 0", arb_err);
        end
        next_cycle();
    endtask

    task automatic test_host_write_read();
        bit is_wr;
        for (int pass = 0; pass < 2; pass++) begin
            is_wr = (pass == 0);
            for (int i = 0; i < 5; i++) begin
                host_req   = (i < 2);
                host_we    = is_wr;
                host_addr  = 20'h00123;
                host_wdata = 8'hA5;
                mid_cycle();
                checks++;
                if (host_ack !== (i == 1) || disp_busy !== (i == 1)) begin
                    errors++;
                    $display("[TB] FAIL host_ack pass=%0d i=%0d: ack=%b busy=%b expected %b",
                             pass, i, host_ack, disp_busy, (i == 1));
                end
                if (i == 1) begin
                    checks++;
                    if (mem_en !== 1'b1 || mem_we !== is_wr || mem_addr !== 20'h00123) begin
                        errors++;
                        $display("[TB] FAIL host_issue pass=%0d: en=%b we=%b addr=%h expected 1 %b 00123",
                                 pass, mem_en, mem_we, mem_addr, is_wr);
                    end
                end
                if (!is_wr) begin
                    checks++;
                    if (host_rvld !== (i == 1 + LATENCY)) begin
                        errors++;
                        $display("[TB] FAIL host_rvld i=%0d: got %b expected %b", i, host_rvld, (i == 1 + LATENCY));
                    end
                    if (i == 1 + LATENCY) begin
                        checks++;
                        if (host_rdata !== 8'hA5) begin
                            errors++;
                            $display("[TB] FAIL host_rdata: got %h expected a5", host_rdata);
                        end
                    end
                end
                next_cycle();
            end
        end
        ref_mem[12'h123] = 8'hA5;
        idle_inputs();
    endtask

    task automatic test_starvation();
        bit                was_disp [0:31];
        logic [AWIDTH-1:0] haddr;
        int                s;
        int                p;
        haddr = 20'h00280;
        for (int j = -10; j <= MAXBURST + 3 + LATENCY; j++) begin
            s = j + 10;
            disp_rd   = (j < MAXBURST + 4) && (j != MAXBURST);
            disp_addr = 20'h00300 + AWIDTH'(s);
            host_req  = (j >= 0) && (j <= MAXBURST);
            host_we   = 1'b0;
            host_addr = haddr;
            was_disp[s] = disp_rd;
            mid_cycle();
            checks++;
            if (disp_busy !== (j == MAXBURST) || host_ack !== (j == MAXBURST)) begin
                errors++;
                $display("[TB] FAIL starve_slot j=%0d: busy=%b ack=%b expected %b",
                         j, disp_busy, host_ack, (j == MAXBURST));
            end
            if (j < MAXBURST + 4) begin
                checks++;
                if (mem_en !== 1'b1 || mem_addr !== ((j == MAXBURST) ? haddr : disp_addr)) begin
                    errors++;
                    $display("[TB] FAIL starve_issue j=%0d: en=%b addr=%h expected 1 %h",
                             j, mem_en, mem_addr, ((j == MAXBURST) ? haddr : disp_addr));
                end
            end
            if (s >= LATENCY) begin
                p = s - LATENCY;
                checks++;
                if (disp_vld !== was_disp[p] || host_rvld !== (j - LATENCY == MAXBURST)) begin
                    errors++;
                    $display("[TB] FAIL starve_return j=%0d: dvld=%b hvld=%b expected %b %b",
                             j, disp_vld, host_rvld, was_disp[p], (j - LATENCY == MAXBURST));
                end
                if (was_disp[p]) begin
                    checks++;
                    if (disp_data !== ref_mem[12'h300 + 12'(p)]) begin
                        errors++;
                        $display("[TB] FAIL starve_ddata j=%0d: got %h expected %h",
                                 j, disp_data, ref_mem[12'h300 + 12'(p)]);
                    end
                end
            end
            next_cycle();
        end
        idle_inputs();
        mid_cycle();
        checks++;
        if (arb_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL starve_err: got %b expected 0", arb_err);
        end
        next_cycle();
    endtask

    task automatic test_interleaved();
        for (int j = -(MAXBURST - 1); j <= 5; j++) begin
            disp_rd   = (j <= 0) || (j == 2);
            disp_addr = (j == 0) ? 20'd5 : (j == 2) ? 20'd6 : 20'h00400 + AWIDTH'(j + MAXBURST);
            host_req  = (j <= 1);
            host_we   = 1'b0;
            host_addr = 20'd9;
            mid_cycle();
            checks++;
            if (host_ack !== (j == 1) || disp_busy !== (j == 1)) begin
                errors++;
                $display("[TB] FAIL inter_slot j=%0d: ack=%b busy=%b expected %b", j, host_ack, disp_busy, (j == 1));
            end
            if (j >= 2) begin
                checks++;
                if (disp_vld !== (j == 2 || j == 4) || host_rvld !== (j == 3)) begin
                    errors++;
                    $display("[TB] FAIL inter_route j=%0d: dvld=%b hvld=%b expected %b %b",
                             j, disp_vld, host_rvld, (j == 2 || j == 4), (j == 3));
                end
            end
            if (j == 2 || j == 4) begin
                checks++;
                if (disp_data !== ref_mem[(j == 2) ? 12'd5 : 12'd6]) begin
                    errors++;
                    $display("[TB] FAIL inter_ddata j=%0d: got %h expected %h",
                             j, disp_data, ref_mem[(j == 2) ? 12'd5 : 12'd6]);
                end
            end
            if (j == 3) begin
                checks++;
                if (host_rdata !== ref_mem[12'd9]) begin
                    errors++;
                    $display("[TB] FAIL inter_hdata: got %h expected %h", host_rdata, ref_mem[12'd9]);
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_reset_midflight();
        for (int j = 0; j < 10; j++) begin
            host_req  = (j < 2);
            host_we   = 1'b0;
            host_addr = 20'h00050;
            disp_rd   = (j == 6);
            disp_addr = 20'h00051;
            if (j == 2) rst_core = 1'b1;
            if (j == 4) rst_core = 1'b0;
            mid_cycle();
            if (j == 1) begin
                checks++;
                if (host_ack !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL rstmid_ack: got %b expected 1", host_ack);
                end
            end
            if (j >= 2 && j <= 5) begin
                checks++;
                if ({disp_busy, disp_vld, host_ack, host_rvld, mem_en, mem_we, arb_err} !== 7'b0) begin
                    errors++;
                    $display("[TB] FAIL rstmid_outputs j=%0d: got %b expected 0000000", j,
                             {disp_busy, disp_vld, host_ack, host_rvld, mem_en, mem_we, arb_err});
                end
            end
            if (j >= 6) begin
                checks++;
                if (host_rvld !== 1'b0 || disp_vld !== (j == 8)) begin
                    errors++;
                    $display("[TB] FAIL rstmid_after j=%0d: hvld=%b dvld=%b expected 0 %b",
                             j, host_rvld, disp_vld, (j == 8));
                end
            end
            if (j == 8) begin
                checks++;
                if (disp_data !== ref_mem[12'h051]) begin
                    errors++;
                    $display("[TB] FAIL rstmid_ddata: got %h expected %h", disp_data, ref_mem[12'h051]);
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_protocol_error();
        for (int j = 0; j < 7; j++) begin
            host_req   = (j < 2);
            host_we    = 1'b1;
            host_addr  = 20'h00060;
            host_wdata = 8'h3C;
            disp_rd    = (j == 1);
            disp_addr  = 20'h00061;
            mid_cycle();
            if (j == 1) begin
                checks++;
                if (host_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 20'h00060 || mem_wdata !== 8'h3C) begin
                    errors++;
                    $display("[TB] FAIL proto_issue: ack=%b we=%b addr=%h wdata=%h expected 1 1 00060 3c",
                             host_ack, mem_we, mem_addr, mem_wdata);
                end
            end
            checks++;
            if (arb_err !== (j >= 2) || disp_vld !== 1'b0) begin
                errors++;
                $display("[TB] FAIL proto_err j=%0d: err=%b dvld=%b expected %b 0", j, arb_err, disp_vld, (j >= 2));
            end
            next_cycle();
        end
        ref_mem[12'h060] = 8'h3C;
        idle_inputs();
        rst_core = 1'b1;
        mid_cycle();
        checks++;
        if (arb_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL proto_err_clear: got %b expected 0", arb_err);
        end
        next_cycle();
        rst_core = 1'b0;
        next_cycle();
    endtask

    // Transaction-level model: host is served once the display leaves a cycle free,
    // or once the display has taken MAXBURST grants while the host waited.
    task automatic test_random();
        ret_t              q[$];
        ret_t              r;
        bit                m_busy;
        bit                prev_busy;
        bit                next_busy;
        int                waited;
        bit                h_req;
        bit                h_we;
        logic [AWIDTH-1:0] h_addr;
        logic [PWIDTH-1:0] h_wdata;
        bit                d_rd;
        logic [AWIDTH-1:0] d_addr;
        bit                active;
        bit                due;
        m_busy = 0; prev_busy = 0; waited = 0;
        h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
        for (int j = 0; j < 400 + LATENCY + 2; j++) begin
            active = (j < 400);
            if (prev_busy) h_req = 0;
            if (!h_req && active && ($urandom_range(0, 99) < 35)) begin
                h_req   = 1;
                h_we    = $urandom_range(0, 1) == 1;
                h_addr  = AWIDTH'($urandom_range(0, 63));
                h_wdata = PWIDTH'($urandom);
            end
            d_rd   = active && !m_busy && ($urandom_range(0, 99) < 60);
            d_addr = AWIDTH'($urandom_range(0, 63));
            disp_rd = d_rd; disp_addr = d_addr;
            host_req = h_req; host_we = h_we; host_addr = h_addr; host_wdata = h_wdata;
            mid_cycle();
            checks++;
            if (disp_busy !== m_busy || host_ack !== m_busy || mem_en !== (m_busy || d_rd)) begin
                errors++;
                $display("[TB] FAIL rand_arb j=%0d: busy=%b ack=%b en=%b expected %b %b %b",
                         j, disp_busy, host_ack, mem_en, m_busy, m_busy, (m_busy || d_rd));
            end
            if (m_busy) begin
                checks++;
                if (mem_we !== h_we || mem_addr !== h_addr || (h_we && mem_wdata !== h_wdata)) begin
                    errors++;
                    $display("[TB] FAIL rand_host_issue j=%0d: we=%b addr=%h wdata=%h expected %b %h %h",
                             j, mem_we, mem_addr, mem_wdata, h_we, h_addr, h_wdata);
                end
            end else if (d_rd) begin
                checks++;
                if (mem_we !== 1'b0 || mem_addr !== d_addr) begin
                    errors++;
                    $display("[TB] FAIL rand_disp_issue j=%0d: we=%b addr=%h expected 0 %h", j, mem_we, mem_addr, d_addr);
                end
            end
            due = (q.size() > 0) && (q[0].due == j);
            checks++;
            if (disp_vld !== (due && q[0].owner) || host_rvld !== (due && !q[0].owner)) begin
                errors++;
                $display("[TB] FAIL rand_return j=%0d: dvld=%b hvld=%b expected %b %b",
                         j, disp_vld, host_rvld, (due && q[0].owner), (due && !q[0].owner));
            end
            if (due) begin
                r = q.pop_front();
                checks++;
                if ((r.owner ? disp_data : host_rdata) !== r.data) begin
                    errors++;
                    $display("[TB] FAIL rand_data j=%0d owner=%b: got %h expected %h",
                             j, r.owner, (r.owner ? disp_data : host_rdata), r.data);
                end
            end
            if (m_busy) begin
                if (h_we) begin
                    ref_mem[h_addr[11:0]] = h_wdata;
                end else begin
                    r.due = j + LATENCY; r.owner = 1'b0; r.data = ref_mem[h_addr[11:0]];
                    q.push_back(r);
                end
            end else if (d_rd) begin
                r.due = j + LATENCY; r.owner = 1'b1; r.data = ref_mem[d_addr[11:0]];
                q.push_back(r);
            end
            next_busy = h_req && !m_busy && (!d_rd || (waited + 1 >= MAXBURST));
            waited    = (!h_req || m_busy) ? 0 : waited + (d_rd ? 1 : 0);
            prev_busy = m_busy;
            m_busy    = next_busy;
            next_cycle();
        end
        idle_inputs();
        mid_cycle();
        checks++;
        if (q.size() != 0 || arb_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rand_drain: pending=%0d err=%b expected 0 0", q.size(), arb_err);
        end
        next_cycle();
    endtask

    initial begin
        idle_inputs();
        rst_core = 1'b1;
        for (int i = 0; i < 4096; i++) ref_mem[i] = seed_data(i);
        test_reset();
        test_display_only();
        test_host_write_read();
        test_starvation();
        test_interleaved();
        test_reset_midflight();
        test_protocol_error();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
